// File: rtl/leb128_pkg.sv
// Shared constants and types for the LEB128 u32 stream decoder.
package leb128_pkg;

    localparam int unsigned LEB128_U32_MAX_BYTES = 5;
    localparam int unsigned LEB128_CHUNK_W       = 7;
    localparam int unsigned LEB128_CONT_BIT      = 7;
    localparam logic [6:0]  LEB128_U32_OVF_MASK  = 7'h70;

    // Byte counter width: holds 0..LEB128_U32_MAX_BYTES-1.
    localparam int unsigned LEB128_CNT_W = 3;

    typedef logic [LEB128_CHUNK_W-1:0] leb128_chunk_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } leb128_dec_state_t;

    // True when the slot being written is the last one a u32 frame may use.
    function automatic logic leb128_is_last_slot(input logic [LEB128_CNT_W-1:0] cnt);
        return cnt == LEB128_CNT_W'(LEB128_U32_MAX_BYTES - 1);
    endfunction

endpackage

// File: rtl/leb128_u32_stream_decoder_unpack_u32.sv
// Combinational LEB128 unpacker: glues up to five 7-bit chunks into a u32.
// A chunk is kept only while every earlier byte carries its continuation
// (glue) bit; bits above bit 31 of the 35-bit glue are discarded.
module unpack_u32
    import leb128_pkg::*;
(
    input  logic [7:0]  i0,
    input  logic [7:0]  i1,
    input  logic [7:0]  i2,
    input  logic [7:0]  i3,
    input  logic [7:0]  i4,
    output logic [31:0] o
);

    logic [LEB128_U32_MAX_BYTES-1:0] keep;
    leb128_chunk_t                   m0, m1, m2, m3, m4;
    logic [34:0]                     full;
    logic                            unused_bits;

    // Chunk N survives only if bytes 0..N-1 all continue.
    always_comb begin
        keep    = '0;
        keep[0] = 1'b1;
        keep[1] = keep[0] & i0[LEB128_CONT_BIT];
        keep[2] = keep[1] & i1[LEB128_CONT_BIT];
        keep[3] = keep[2] & i2[LEB128_CONT_BIT];
        keep[4] = keep[3] & i3[LEB128_CONT_BIT];
    end

    // Mask dropped chunks and glue the survivors little-endian.
    always_comb begin
        m0   = keep[0] ? i0[LEB128_CHUNK_W-1:0] : '0;
        m1   = keep[1] ? i1[LEB128_CHUNK_W-1:0] : '0;
        m2   = keep[2] ? i2[LEB128_CHUNK_W-1:0] : '0;
        m3   = keep[3] ? i3[LEB128_CHUNK_W-1:0] : '0;
        m4   = keep[4] ? i4[LEB128_CHUNK_W-1:0] : '0;
        full = {m4, m3, m2, m1, m0};
        o    = full[31:0];
    end

    // The top three glued bits and the last glue bit cannot reach a u32.
    assign unused_bits = ^{full[34:32], i4[LEB128_CONT_BIT]};

endmodule

// File: rtl/leb128_u32_stream_decoder.sv
// Byte-serial LEB128 u32 decoder: collects a 1-5 byte frame into chunk
// slots and presents the unpacked value on a valid/ready output stream.
module leb128_u32_stream_decoder
    import leb128_pkg::*;
#(
    parameter bit STRICT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_len,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready
);

    leb128_dec_state_t state_q, state_d;

    leb128_chunk_t [LEB128_U32_MAX_BYTES-1:0] slot_q, slot_d;
    logic [LEB128_CNT_W-1:0]                  cnt_q, cnt_d;
    logic [2:0]                               len_q, len_d;
    logic                                     err_q, err_d;

    leb128_chunk_t chunk;
    logic          cont;
    logic          last_slot;
    logic          accept;
    logic          frame_end;
    logic          overflow;

    assign chunk     = in_data[LEB128_CHUNK_W-1:0];
    assign cont      = in_data[LEB128_CONT_BIT];
    assign last_slot = leb128_is_last_slot(cnt_q);
    assign accept    = in_valid & in_ready;
    // The fifth byte closes the frame whatever its continuation bit says.
    assign frame_end = accept & (~cont | last_slot);
    assign overflow  = STRICT & (|(chunk & LEB128_U32_OVF_MASK));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a finished frame always lands in HOLD, even on a pop cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: begin
                if (frame_end) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (frame_end) begin
                    state_d = HOLD;
                end else if (out_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Handshake outputs; in_ready never looks at in_valid.
    always_comb begin
        out_valid = (state_q == HOLD);
        in_ready  = ~out_valid | out_ready;
    end

    // Slot, counter, length and error next-state.
    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        err_d  = err_q;
        if (accept) begin
            // A new frame wipes stale chunks so the unpacker sees zeros.
            if (cnt_q == '0) begin
                for (int i = 1; i < LEB128_U32_MAX_BYTES; i++) begin
                    slot_d[i] = '0;
                end
            end
            for (int i = 0; i < LEB128_U32_MAX_BYTES; i++) begin
                if (cnt_q == LEB128_CNT_W'(i)) begin
                    slot_d[i] = chunk;
                end
            end
            if (frame_end) begin
                cnt_d = '0;
                len_d = cnt_q + 3'd1;
                err_d = last_slot & (cont | overflow);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            err_q  <= err_d;
        end
    end

    // Glue bits forced high so every stored chunk contributes.
    unpack_u32 u_unpack (
        .i0 ({1'b1, slot_q[0]}),
        .i1 ({1'b1, slot_q[1]}),
        .i2 ({1'b1, slot_q[2]}),
        .i3 ({1'b1, slot_q[3]}),
        .i4 ({1'b1, slot_q[4]}),
        .o  (out_data)
    );

    assign out_len = len_q;
    assign out_err = err_q;

    // Counter stays inside the five-slot window.
    cnt_in_range: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= LEB128_CNT_W'(LEB128_U32_MAX_BYTES - 1));

    // Held results do not move until popped.
    hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid & ~out_ready) |=> ($stable(out_data) & $stable(out_len) & $stable(out_err)));

endmodule

// File: tb/tb_leb128_u32_stream_decoder.sv
module tb_leb128_u32_stream_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_data;
    logic [2:0]  out_len;
    logic        lax_in_ready, lax_out_valid, lax_out_err;
    logic [31:0] lax_out_data;
    logic [2:0]  lax_out_len;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending output and the partially received frame.
    bit          m_valid;
    logic [31:0] m_data;
    logic [2:0]  m_len;
    bit          m_err_strict;
    bit          m_err_lax;
    logic [7:0]  m_frame[$];
    bit          exp_ready;
    logic        obs_ready;
    logic        obs_ready_lax;

    leb128_u32_stream_decoder #(.STRICT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    leb128_u32_stream_decoder #(.STRICT(1'b0)) dut_lax (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (lax_in_ready),
        .out_data  (lax_out_data),
        .out_len   (lax_out_len),
        .out_err   (lax_out_err),
        .out_valid (lax_out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Decode a complete frame arithmetically: value = sum(chunk_i * 128^i) mod 2^32.
    function automatic void model_finish_frame();
        logic [63:0] v;
        logic [7:0]  last;
        int          n;
        v = '0;
        n = m_frame.size();
        for (int i = 0; i < n; i++) begin
            v = v + (64'(m_frame[i] & 8'h7f) << (7 * i));
        end
        last         = m_frame[n - 1];
        m_data       = v[31:0];
        m_len        = 3'(n);
        m_err_lax    = (n == 5) && last[7];
        m_err_strict = m_err_lax || ((n == 5) && ((last & 8'h70) != 8'h00));
        m_valid      = 1'b1;
        m_frame.delete();
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_frame.delete();
    endfunction

    // Drive one cycle (called at a negedge), sample in_ready before the edge,
    // advance the model, and return at the next negedge.
    task automatic drive(input bit iv, input logic [7:0] id, input bit ordy);
        bit acc;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        obs_ready     = in_ready;
        obs_ready_lax = lax_in_ready;
        exp_ready     = !m_valid || ordy;
        acc           = iv && exp_ready;
        if (m_valid && ordy) m_valid = 1'b0;
        if (acc) begin
            m_frame.push_back(id);
            if (!id[7] || m_frame.size() == 5) model_finish_frame();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || out_len !== 3'd0 ||
            out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: valid=%b err=%b len=%0d data=%h ready=%b, want 0 0 0 00000000 1",
                     out_valid, out_err, out_len, out_data, in_ready);
        end
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || lax_out_valid !== 1'b0 || obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: valid=%b lax_valid=%b ready=%b, want 0 0 1",
                     out_valid, lax_out_valid, obs_ready);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 8'h05, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h5 || out_len !== 3'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL single_byte: valid=%b data=%h len=%0d err=%b, want 1 00000005 1 0",
                     out_valid, out_data, out_len, out_err);
        end
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'he5, 1'b1);
        drive(1'b1, 8'h8e, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_partial: valid=%b, want 0", out_valid);
        end
        drive(1'b1, 8'h26, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00098765 || out_len !== 3'd3 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_three: valid=%b data=%h len=%0d err=%b, want 1 00098765 3 0",
                     out_valid, out_data, out_len, out_err);
        end
        drive(1'b1, 8'h7f, 1'b1);
        checks++;
        if (obs_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h7f ||
            out_len !== 3'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_bubble: ready=%b valid=%b data=%h len=%0d err=%b, want 1 1 0000007f 1 0",
                     obs_ready, out_valid, out_data, out_len, out_err);
        end
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_max_and_overflow();
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hff, 1'b1);
        drive(1'b1, 8'h0f, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hffffffff || out_len !== 3'd5 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL max_value: valid=%b data=%h len=%0d err=%b, want 1 ffffffff 5 0",
                     out_valid, out_data, out_len, out_err);
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hff, 1'b1);
        drive(1'b1, 8'h1f, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hffffffff || out_len !== 3'd5 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_strict: valid=%b data=%h len=%0d err=%b, want 1 ffffffff 5 1",
                     out_valid, out_data, out_len, out_err);
        end
        checks++;
        if (lax_out_valid !== 1'b1 || lax_out_data !== 32'hffffffff || lax_out_len !== 3'd5 ||
            lax_out_err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_lax: valid=%b data=%h len=%0d err=%b, want 1 ffffffff 5 0",
                     lax_out_valid, lax_out_data, lax_out_len, lax_out_err);
        end
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_unterminated();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h80, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0 || out_len !== 3'd5 || out_err !== 1'b1 ||
            lax_out_err !== 1'b1) begin
            errors++;
            $display("FAIL unterminated: valid=%b data=%h len=%0d err=%b lax_err=%b, want 1 00000000 5 1 1",
                     out_valid, out_data, out_len, out_err, lax_out_err);
        end
        drive(1'b1, 8'h01, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h1 || out_len !== 3'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL after_unterminated: valid=%b data=%h len=%0d err=%b, want 1 00000001 1 0",
                     out_valid, out_data, out_len, out_err);
        end
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_hold();
        drive(1'b1, 8'hac, 1'b0);
        drive(1'b1, 8'h02, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 8'h55, 1'b0);
            checks++;
            if (obs_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h12c ||
                out_len !== 3'd2 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: ready=%b valid=%b data=%h len=%0d err=%b, want 0 1 0000012c 2 0",
                         c, obs_ready, out_valid, out_data, out_len, out_err);
            end
        end
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (obs_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_pop: ready=%b valid=%b, want 1 0", obs_ready, out_valid);
        end
    endtask

    task automatic test_reset_midframe();
        drive(1'b1, 8'h81, 1'b1);
        drive(1'b1, 8'h82, 1'b1);
        rst      = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || lax_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: valid=%b lax_valid=%b, want 0 0", out_valid, lax_out_valid);
        end
        drive(1'b1, 8'h7f, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h7f || out_len !== 3'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_frame: valid=%b data=%h len=%0d err=%b, want 1 0000007f 1 0",
                     out_valid, out_data, out_len, out_err);
        end
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        bit          iv, ordy;
        logic [7:0]  b;
        for (int c = 0; c < 800; c++) begin
            iv   = ($urandom_range(0, 9) < 8);
            ordy = ($urandom_range(0, 9) < 7);
            b    = 8'($urandom);
            // Bias towards continuation so long and 5-byte frames are common.
            b[7] = ($urandom_range(0, 3) != 0);
            drive(iv, b, ordy);
            checks++;
            if (obs_ready !== exp_ready || obs_ready_lax !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready cyc%0d: strict=%b lax=%b, want %b",
                         c, obs_ready, obs_ready_lax, exp_ready);
            end
            checks++;
            if (out_valid !== m_valid || lax_out_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_valid cyc%0d: strict=%b lax=%b, want %b",
                         c, out_valid, lax_out_valid, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (out_data !== m_data || out_len !== m_len || out_err !== m_err_strict) begin
                    errors++;
                    $display("FAIL rand_strict cyc%0d: data=%h len=%0d err=%b, want %h %0d %b",
                             c, out_data, out_len, out_err, m_data, m_len, m_err_strict);
                end
                checks++;
                if (lax_out_data !== m_data || lax_out_len !== m_len || lax_out_err !== m_err_lax) begin
                    errors++;
                    $display("FAIL rand_lax cyc%0d: data=%h len=%0d err=%b, want %h %0d %b",
                             c, lax_out_data, lax_out_len, lax_out_err, m_data, m_len, m_err_lax);
                end
            end
        end
        drive(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_max_and_overflow();
        test_unterminated();
        test_hold();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
